// File: rtl/protocol_packet_receiver_pkg.sv
// Shared definitions for the packet receiver: command codes, payload-length
// table, receive FSM states and the CRC8 polynomial.
package protocol_packet_receiver_pkg;

    localparam logic [7:0] CRC_POLY = 8'h07;

    localparam logic [7:0] CMD_D0 = 8'hD0;
    localparam logic [7:0] CMD_21 = 8'h21;
    localparam logic [7:0] CMD_F1 = 8'hF1;
    localparam logic [7:0] CMD_F3 = 8'hF3;
    localparam logic [7:0] CMD_F5 = 8'hF5;
    localparam logic [7:0] CMD_E4 = 8'hE4;
    localparam logic [7:0] CMD_C5 = 8'hC5;
    localparam logic [7:0] CMD_B2 = 8'hB2;

    typedef enum logic [2:0] {
        IDLE,
        CMD_DONE,
        DATA,
        CRC_CHECK,
        HOLD
    } rx_state_t;

    // Number of data bytes that follow a command; the transmitter uses the same table.
    function automatic logic [7:0] cmd_length(input logic [7:0] cmd);
        case (cmd)
            CMD_D0, CMD_B2:         cmd_length = 8'd1;
            CMD_F1, CMD_E4, CMD_C5: cmd_length = 8'd6;
            default:                cmd_length = 8'd0;
        endcase
    endfunction

    function automatic logic cmd_known(input logic [7:0] cmd);
        case (cmd)
            CMD_D0, CMD_21, CMD_F1, CMD_F3,
            CMD_F5, CMD_E4, CMD_C5, CMD_B2: cmd_known = 1'b1;
            default:                        cmd_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/protocol_packet_receiver_crc.sv
// One-byte CRC8 step (MSB first, no reflection): next CRC from current CRC and a byte.
module crc8_byte_update
    import protocol_packet_receiver_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] next_crc
);

    logic [7:0] acc;

    always_comb begin
        acc = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ((acc << 1) ^ CRC_POLY) : (acc << 1);
        end
        next_crc = acc;
    end

endmodule

// File: rtl/protocol_packet_receiver.sv
// Byte-stream packet receiver: command, table-sized payload, CRC8 check, then
// holds the packet until acknowledged. Reports CRC, command, timeout and overrun errors.
module protocol_packet_receiver
    import protocol_packet_receiver_pkg::*;
#(
    parameter int BYTE_LENGTH    = 8,
    parameter int BUFFER_LENGTH  = 24,
    parameter int COUNTER_SIZE   = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                recv_interface_done,
    input  logic [7:0]                          recv_interface_in_byte,
    input  logic                                flush,
    input  logic                                packet_ack,
    output logic [7:0]                          in_cmd,
    output logic [BYTE_LENGTH*BUFFER_LENGTH-1:0] in_data,
    output logic                                packet_ready,
    output logic                                crc_error,
    output logic                                cmd_error,
    output logic                                timeout_error,
    output logic                                overrun
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    rx_state_t state, state_n;
    logic [7:0] byte_q;
    logic done_q, done_d, flush_q, flush_d, ack_q, ack_d;
    logic byte_edge, flush_edge, ack_edge;
    logic [COUNTER_SIZE-1:0] cnt, cnt_n, len, len_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [7:0] crc, crc_n, crc_base, crc_upd;
    logic [7:0] cmd_n;
    logic [BYTE_LENGTH*BUFFER_LENGTH-1:0] data_n;
    logic ready_n, crc_err_n, cmd_err_n, to_err_n, ovr_n;

    assign byte_edge  = done_q & ~done_d;
    assign flush_edge = flush_q & ~flush_d;
    assign ack_edge   = ack_q & ~ack_d;

    // The command byte seeds the CRC from zero; later bytes chain on the running value.
    assign crc_base = (state == IDLE) ? 8'h00 : crc;

    crc8_byte_update u_crc (
        .crc      (crc_base),
        .data     (byte_q),
        .next_crc (crc_upd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            {done_q, done_d, flush_q, flush_d, ack_q, ack_d} <= '0;
            byte_q <= '0;
            cnt <= '0;
            len <= '0;
            timer <= '0;
            crc <= '0;
            in_cmd <= '0;
            in_data <= '0;
            {packet_ready, crc_error, cmd_error, timeout_error, overrun} <= '0;
        end else begin
            state <= state_n;
            done_q <= recv_interface_done;
            done_d <= done_q;
            flush_q <= flush;
            flush_d <= flush_q;
            ack_q <= packet_ack;
            ack_d <= ack_q;
            byte_q <= recv_interface_in_byte;
            cnt <= cnt_n;
            len <= len_n;
            timer <= timer_n;
            crc <= crc_n;
            in_cmd <= cmd_n;
            in_data <= data_n;
            {packet_ready, crc_error, cmd_error, timeout_error, overrun} <=
                {ready_n, crc_err_n, cmd_err_n, to_err_n, ovr_n};
        end
    end

    always_comb begin
        state_n = state;
        cmd_n = in_cmd;
        data_n = in_data;
        len_n = len;
        cnt_n = cnt;
        crc_n = crc;
        timer_n = timer;
        ready_n = packet_ready;
        crc_err_n = crc_error;
        cmd_err_n = cmd_error;
        to_err_n = timeout_error;
        ovr_n = overrun;
        if (flush_edge) begin
            state_n = IDLE;
            ready_n = 1'b0;
            cnt_n = '0;
            timer_n = '0;
        end else if ((state == DATA || state == CRC_CHECK) && !byte_edge && timer == TIMER_LAST) begin
            state_n = IDLE;
            to_err_n = 1'b1;
            cnt_n = '0;
            timer_n = '0;
        end else begin
            if (state == CMD_DONE || state == DATA || state == CRC_CHECK) begin
                timer_n = byte_edge ? '0 : timer + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (byte_edge) begin
                        cmd_n = byte_q;
                        len_n = COUNTER_SIZE'(cmd_length(byte_q));
                        cnt_n = '0;
                        timer_n = '0;
                        data_n = '0;
                        crc_n = crc_upd;
                        {crc_err_n, cmd_err_n, to_err_n, ovr_n} = '0;
                        state_n = CMD_DONE;
                    end
                end
                CMD_DONE: begin
                    if (!cmd_known(in_cmd)) begin
                        cmd_err_n = 1'b1;
                        timer_n = '0;
                        state_n = IDLE;
                    end else if (len == '0) begin
                        state_n = CRC_CHECK;
                    end else begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (byte_edge) begin
                        data_n[int'(cnt)*BYTE_LENGTH +: BYTE_LENGTH] = byte_q;
                        crc_n = crc_upd;
                        cnt_n = cnt + 1'b1;
                        if (cnt + 1'b1 == len) state_n = CRC_CHECK;
                    end
                end
                CRC_CHECK: begin
                    if (byte_edge) begin
                        if (byte_q == crc) begin
                            ready_n = 1'b1;
                            state_n = HOLD;
                        end else begin
                            crc_err_n = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                HOLD: begin
                    // An ack in the same cycle as a byte still releases; the byte is lost either way.
                    if (ack_edge) begin
                        ready_n = 1'b0;
                        state_n = IDLE;
                    end
                    if (byte_edge) ovr_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
